// File: rtl/gated_dff_pkg.sv
// -----------------------------------------------------------------------------
// gated_dff_pkg
//   Shared definitions for the gated D flip-flop and its users.
//   - GATED_DFF_WIDTH : default data width of the flop
//   - RV_MAX_W        : width of the RESET_VALUE parameter container
//   - dff_data_t      : data type at the default width, for benches/instantiators
// -----------------------------------------------------------------------------
package gated_dff_pkg;

    localparam int GATED_DFF_WIDTH = 1;

    // RESET_VALUE is carried in a fixed-width container so that an oversized
    // value can be detected at elaboration instead of being silently truncated.
    localparam int RV_MAX_W = 64;

    typedef logic [GATED_DFF_WIDTH-1:0] dff_data_t;

endpackage

// File: rtl/gated_dff.sv
// -----------------------------------------------------------------------------
// gated_dff
//   D flip-flop with capture strobe and complementary outputs.
//   q loads d on a rising clk while the capture qualifier is true, otherwise
//   holds. qn is the combinational complement of q (no second register).
//
//   Optional feature (macro GATED_DFF_EDGE_CP_EN):
//     defined   - capture only on the first edge of a cp high level
//                 (cp & ~cp_q, with cp_q a registered copy of cp, reset 0)
//     undefined - capture on every edge where cp is high
//
//   Parameters
//     WIDTH       : data width of d, q, qn (>= 1)
//     RESET_VALUE : value forced onto q while rst_n is low (must fit WIDTH)
//
//   Ports
//     clk   in   rising-edge clock
//     rst_n in   asynchronous active-low reset
//     cp    in   capture strobe, sampled at rising clk
//     d     in   [WIDTH] data to capture
//     q     out  [WIDTH] stored value
//     qn    out  [WIDTH] bitwise complement of q
// -----------------------------------------------------------------------------
module gated_dff
    import gated_dff_pkg::*;
#(
    parameter int                  WIDTH       = GATED_DFF_WIDTH,
    parameter logic [RV_MAX_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cp,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    // Elaboration checks
    if (WIDTH < 1) begin : g_bad_width
        $error("gated_dff: WIDTH must be >= 1");
    end
    if (WIDTH < RV_MAX_W) begin : g_rv_check
        if ((RESET_VALUE >> WIDTH) != '0) begin : g_bad_rv
            $error("gated_dff: RESET_VALUE does not fit in WIDTH bits");
        end
    end

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

    logic cap_en;

`ifdef GATED_DFF_EDGE_CP_EN
    // Registered copy of the strobe; a held-high cp captures only once.
    logic cp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cp_q <= 1'b0;
        else        cp_q <= cp;
    end

    always_comb begin
        cap_en = cp & ~cp_q;
    end
`else
    always_comb begin
        cap_en = cp;
    end
`endif

    // Reset has priority over a capture on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      q <= RST_Q;
        else if (cap_en) q <= d;
    end

    assign qn = ~q;

endmodule

// File: tb/tb_gated_dff.sv
// -----------------------------------------------------------------------------
// tb_gated_dff
//   Scoreboard bench for gated_dff (WIDTH=1, RESET_VALUE=0). Each clocked step
//   pushes the model's expected q to a queue before the edge and pops/compares
//   it one time unit after the edge. Build with or without
//   GATED_DFF_EDGE_CP_EN; the model follows the same macro.
// -----------------------------------------------------------------------------
module tb_gated_dff;
    import gated_dff_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      cp;
    dff_data_t d;
    dff_data_t q;
    dff_data_t qn;

    gated_dff #(
        .WIDTH       (GATED_DFF_WIDTH),
        .RESET_VALUE ('0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cp    (cp),
        .d     (d),
        .q     (q),
        .qn    (qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    dff_data_t m_q;
    logic      m_cpq;
    dff_data_t sb[$];

`ifdef GATED_DFF_EDGE_CP_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    task automatic model_reset();
        m_q   = '0;
        m_cpq = 1'b0;
    endtask

    // One clock: drive cp/d at negedge, push expectation, check after posedge.
    // keep=0 drops cp just after the edge.
    task automatic step(input logic cp_v, input dff_data_t d_v, input bit keep,
                        input string name);
        dff_data_t exp_q;
        @(negedge clk);
        cp = cp_v;
        d  = d_v;
        if (cp_v && (!EDGE_MODE || !m_cpq)) m_q = d_v;
        m_cpq = cp_v;
        sb.push_back(m_q);
        @(posedge clk);
        #1;
        if (!keep) cp = 1'b0;
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, q=%b", name, q);
        end else begin
            exp_q = sb.pop_front();
            if (q !== exp_q) begin
                errors++;
                $display("FAIL %s q: got %b expected %b", name, q, exp_q);
            end
            vectors++;
            if (qn !== ~exp_q) begin
                errors++;
                $display("FAIL %s qn: got %b expected %b", name, qn, ~exp_q);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cp    = 1'b1;
        d     = '1;
        model_reset();
        #2;
        vectors++;
        if (q !== 1'b0 || qn !== 1'b1) begin
            errors++;
            $display("FAIL reset_t0: got q=%b qn=%b expected q=0 qn=1", q, qn);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (q !== 1'b0 || qn !== 1'b1) begin
            errors++;
            $display("FAIL reset_clocked: got q=%b qn=%b expected q=0 qn=1", q, qn);
        end
        @(negedge clk);
        cp    = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 7; i++) step(1'b0, dff_data_t'(i % 2), 1'b0, "hold");
    endtask

    task automatic test_capture();
        step(1'b1, 1'b1, 1'b0, "capture_one");
        step(1'b0, 1'b0, 1'b0, "capture_one_hold");
        step(1'b1, 1'b0, 1'b0, "capture_zero");
        step(1'b0, 1'b1, 1'b0, "capture_zero_hold");
    endtask

    // Strobes separated by idle cycles in which d is driven opposite.
    task automatic test_sequence();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, dff_data_t'(i % 2), 1'b0, "seq_strobe");
            step(1'b0, dff_data_t'((i + 1) % 2), 1'b0, "seq_idle");
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 1'b0, "areset_load");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cp    = 1'b1;
        d     = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (q !== 1'b0 || qn !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: got q=%b qn=%b expected q=0 qn=1", q, qn);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL areset_release: got q=%b expected 0", q);
        end
        // cp still high: the first edge after release captures.
        step(1'b1, 1'b1, 1'b1, "areset_first_capture");
    endtask

    task automatic test_level_vs_edge();
        step(1'b0, 1'b0, 1'b0, "lvl_idle");
        step(1'b1, 1'b1, 1'b1, "lvl_e1");
        step(1'b1, 1'b0, 1'b1, "lvl_e2");
        step(1'b1, 1'b0, 1'b0, "lvl_e3");
        vectors++;
        if (q !== (EDGE_MODE ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL lvl_final: got q=%b expected %b", q, EDGE_MODE ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_capture();
        test_sequence();
        test_async_reset();
        test_level_vs_edge();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d leftover expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
